result_mux_arbiter: RTL and testbench

//  Shares the 4-bit ALU result mux (mux2x1_4bit) between two result producers.

---
 rtl/alu_pkg.sv | 7 +
 rtl/mux2x1_4bit.sv | 11 +
 rtl/result_mux_arbiter.sv | 59 +++++
 tb/tb_result_mux_arbiter.sv | 134 +++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU width, requester source indices and output stage state encodings
package alu_pkg;
  localparam int ALU_W = 4;
  localparam logic SRC_REQ0 = 1'b0;
  localparam logic SRC_REQ1 = 1'b1;
  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_e;
endpackage

// File: rtl/mux2x1_4bit.sv
// mux2x1_4bit: ALU result mux; ports result1 (sel=0), result2 (sel=1), sel, result
module mux2x1_4bit
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0] result1,
  input  logic [ALU_W-1:0] result2,
  input  logic             sel,
  output logic [ALU_W-1:0] result
);
  assign result = sel ? result2 : result1;
endmodule

// File: rtl/result_mux_arbiter.sv
// result_mux_arbiter: two-requester arbiter driving mux2x1_4bit sel into a one-entry valid/ready output stage; ports clk, rst_n, rr_en, reqN_valid/data/ready, sel, out_valid/data/src, out_ready
module result_mux_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rr_en,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  input  logic             out_ready
);
  state_e state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d, mux_y;
  logic src_q, src_d, last_grant_q, last_grant_d;
  logic can_load, load;
  mux2x1_4bit u_mux (
    .result1(req0_data),
    .result2(req1_data),
    .sel    (sel),
    .result (mux_y)
  );
  always_comb begin
    can_load = (state_q == ST_EMPTY) | out_ready;
    sel = (req0_valid & req1_valid) ? (rr_en ? ~last_grant_q : SRC_REQ0) : (req1_valid ? SRC_REQ1 : SRC_REQ0);
    load = (req0_valid | req1_valid) & can_load & rst_n;
    req0_ready = load & (sel == SRC_REQ0);
    req1_ready = load & (sel == SRC_REQ1);
    state_d = load ? ST_FULL : (out_ready ? ST_EMPTY : state_q);
    data_d = load ? mux_y : data_q;
    src_d = load ? sel : src_q;
    last_grant_d = load ? sel : last_grant_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      data_q <= '0;
      src_q <= SRC_REQ0;
      last_grant_q <= SRC_REQ1;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      src_q <= src_d;
      last_grant_q <= last_grant_d;
    end
  end
  assign out_valid = (state_q == ST_FULL);
  assign out_data = data_q;
  assign out_src = src_q;
endmodule

// File: tb/tb_result_mux_arbiter.sv
// tb_result_mux_arbiter: directed stimulus with a queue scoreboard checked by an independent output monitor
module tb_result_mux_arbiter;
  logic clk = 1'b0, rst_n = 1'b0, rr_en = 1'b0;
  logic req0_valid = 1'b0, req1_valid = 1'b0, out_ready = 1'b0;
  logic [3:0] req0_data = '0, req1_data = '0;
  logic req0_ready, req1_ready, sel, out_valid, out_src;
  logic [3:0] out_data;
  int total = 0, bad = 0;
  logic [4:0] exp_q[$];
  result_mux_arbiter dut (
    .clk(clk), .rst_n(rst_n), .rr_en(rr_en),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .sel(sel), .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_ready(out_ready)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input int a, input int e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got data=%0h src=%0d expected nothing", out_data, out_src);
      end else begin
        logic [4:0] e;
        e = exp_q.pop_front();
        if ({out_src, out_data} !== e) begin
          bad++;
          $display("FAIL sb_word: got data=%0h src=%0d expected data=%0h src=%0d", out_data, out_src, e[3:0], e[4]);
        end
      end
    end
  end
  initial begin
    logic [3:0] rr_d[4] = '{4'h3, 4'hC, 4'h3, 4'hC};
    #1;
    req0_valid = 1; req1_valid = 1; req0_data = 4'h1; req1_data = 4'h2; out_ready = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_ready0", req0_ready, 0);
      chk("rst_ready1", req1_ready, 0);
      step();
    end
    rst_n = 1; req0_valid = 0; req1_valid = 0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_src", out_src, 0);
    step();
    req0_valid = 1; req0_data = 4'hA; exp_q.push_back({1'b0, 4'hA});
    @(negedge clk);
    chk("single_ready0", req0_ready, 1);
    chk("single_ready1", req1_ready, 0);
    step();
    req0_valid = 0;
    @(negedge clk);
    chk("single_out_valid", out_valid, 1);
    step();
    rst_n = 0;
    step();
    rst_n = 1; rr_en = 1; req0_valid = 1; req1_valid = 1; req0_data = 4'h3; req1_data = 4'hC;
    for (int i = 0; i < 4; i++) exp_q.push_back({i[0], rr_d[i]});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rr_sel", sel, i % 2);
      chk("rr_ready1", req1_ready, i % 2);
      step();
    end
    req0_valid = 0; req1_valid = 0;
    step();
    step();
    rr_en = 0; req0_valid = 1; req1_valid = 1;
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, 4'h3});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("fixed_ready0", req0_ready, 1);
      chk("fixed_ready1", req1_ready, 0);
      step();
    end
    req0_valid = 0; req1_valid = 0;
    step();
    step();
    req0_valid = 1; req0_data = 4'h5; exp_q.push_back({1'b0, 4'h5});
    step();
    req0_valid = 0; out_ready = 0; req1_valid = 1; req1_data = 4'h9;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_ready1", req1_ready, 0);
      chk("bp_out_data", out_data, 4'h5);
      chk("bp_out_valid", out_valid, 1);
      step();
    end
    out_ready = 1; exp_q.push_back({1'b1, 4'h9});
    @(negedge clk);
    chk("bp_release_ready1", req1_ready, 1);
    step();
    req1_valid = 0;
    step();
    step();
    req0_valid = 1; req0_data = 4'h7; out_ready = 0;
    @(negedge clk);
    chk("mid_load_ready0", req0_ready, 1);
    step();
    req0_valid = 0; rst_n = 0;
    @(negedge clk);
    chk("mid_held_data", out_data, 4'h7);
    step();
    rst_n = 1; rr_en = 1; out_ready = 1; req0_valid = 1; req1_valid = 1;
    req0_data = 4'h3; req1_data = 4'hC; exp_q.push_back({1'b0, 4'h3});
    @(negedge clk);
    chk("mid_out_valid", out_valid, 0);
    chk("mid_out_data", out_data, 0);
    chk("mid_sel", sel, 0);
    chk("mid_ready0", req0_ready, 1);
    step();
    req0_valid = 0; req1_valid = 0;
    step();
    step();
    chk("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
